// File: rtl/hw_sw_mmio_bridge_pkg.sv
// rtl/hw_sw_mmio_bridge_pkg.sv - register map constants shared by the MMIO bridge
package sw_if_pkg;

  localparam int ADDR_CTRL      = 0;
  localparam int ADDR_STATUS    = 1;
  localparam int ADDR_PORT_BASE = 2;

  localparam logic [1:0] CTRL_MODE_EXPERIMENT = 2'd2;

  // STATUS is {full, ovf, nonempty}, each field N_PORTS wide
  localparam int STATUS_NONEMPTY_OFS = 0;
  function automatic int status_ovf_ofs(input int n_ports);
    return n_ports;
  endfunction
  function automatic int status_full_ofs(input int n_ports);
    return 2 * n_ports;
  endfunction

endpackage

// File: rtl/hw_sw_mmio_bridge_if.sv
// rtl/hw_sw_mmio_bridge_if.sv - Avalon-MM slave bus between the HPS driver and the bridge
interface hw_sw_mmio_bridge_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/hw_sw_mmio_bridge_meta_fifo.sv
// rtl/hw_sw_mmio_bridge_meta_fifo.sv - synchronous egress metadata FIFO with head-of-queue output
module meta_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok, push_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign head_o     = mem_q[rptr_q];
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign overflow_o = push_i && !push_ok;

  always_comb begin
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/hw_sw_mmio_bridge.sv
// rtl/hw_sw_mmio_bridge.sv - Avalon-MM slave: control register, per-port tx pulses, per-port egress FIFOs
module hw_sw_mmio_bridge
  import sw_if_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  hw_sw_mmio_bridge_if.slave          bus,
  input  logic [N_PORTS-1:0]          in_valid,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  output logic [N_PORTS-1:0]          out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        experimenting
);
  logic [DATA_W-1:0]    ctrl_q, ctrl_d;
  logic [DATA_W-1:0]    readdata_q, readdata_d;
  logic [N_PORTS-1:0]   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [N_PORTS-1:0]   ovf_q, ovf_d;

  logic                 wr_en, rd_en, sel_ctrl, sel_status;
  logic [N_PORTS-1:0]   sel_port, pop, full, empty, ovf_evt, ovf_clr;
  logic [3*N_PORTS-1:0] status;
  logic [DATA_W-1:0]    head [N_PORTS];

  assign wr_en      = bus.chipselect && bus.write;
  assign rd_en      = bus.chipselect && bus.read;
  assign sel_ctrl   = (bus.address == ADDR_W'(ADDR_CTRL));
  assign sel_status = (bus.address == ADDR_W'(ADDR_STATUS));

  always_comb begin
    sel_port = '0;
    for (int i = 0; i < N_PORTS; i++)
      sel_port[i] = (bus.address == ADDR_W'(ADDR_PORT_BASE + i));
  end

  assign pop    = rd_en ? sel_port : '0;
  assign status = {full, ovf_q, ~empty};

  genvar g;
  generate
    for (g = 0; g < N_PORTS; g++) begin : g_fifo
      meta_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (in_valid[g]),
        .data_i     (in_data[g*DATA_W +: DATA_W]),
        .pop_i      (pop[g]),
        .head_o     (head[g]),
        .full_o     (full[g]),
        .empty_o    (empty[g]),
        .overflow_o (ovf_evt[g])
      );
    end
  endgenerate

  // A same-cycle overflow beats a software clear so no drop goes unreported
  assign ovf_clr = (wr_en && sel_status) ? bus.writedata[N_PORTS +: N_PORTS] : '0;
  assign ovf_d   = (ovf_q & ~ovf_clr) | ovf_evt;
  assign ctrl_d  = (wr_en && sel_ctrl) ? bus.writedata : ctrl_q;

  always_comb begin
    out_valid_d = wr_en ? sel_port : '0;
    out_data_d  = (wr_en && |sel_port) ? bus.writedata : '0;
  end

  always_comb begin
    readdata_d = '0;
    if (rd_en) begin
      if (sel_ctrl) readdata_d = ctrl_q;
      else if (sel_status) readdata_d = DATA_W'(status);
      else begin
        for (int i = 0; i < N_PORTS; i++)
          if (sel_port[i] && !empty[i]) readdata_d = head[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      readdata_q  <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      ovf_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      readdata_q  <= readdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.readdata  = readdata_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign experimenting = (ctrl_q[1:0] == CTRL_MODE_EXPERIMENT);
endmodule

// File: tb/tb_hw_sw_mmio_bridge.sv
// tb/tb_hw_sw_mmio_bridge.sv - self-checking bench for hw_sw_mmio_bridge against a queue-based model
module tb_hw_sw_mmio_bridge;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   in_valid;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]   out_valid;
  logic [DW-1:0]   out_data;
  logic            experimenting;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  hw_sw_mmio_bridge_if #(.ADDR_W(4), .DATA_W(DW)) bus ();

  hw_sw_mmio_bridge #(.N_PORTS(NP), .DATA_W(DW), .ADDR_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .experimenting (experimenting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue per port, plain register values
  logic [31:0] mq [NP][$];
  logic [31:0] ctrl_m;
  logic [NP-1:0] ovf_m;
  logic [31:0] exp_rd;
  logic [NP-1:0] exp_ov;
  logic [31:0] exp_od;

  function automatic logic [31:0] status_m();
    logic [31:0] s = '0;
    for (int p = 0; p < NP; p++) begin
      s[p]        = (mq[p].size() > 0);
      s[NP + p]   = ovf_m[p];
      s[2*NP + p] = (mq[p].size() == DEPTH);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) mq[p].delete();
      ctrl_m = '0; ovf_m = '0; exp_rd = '0; exp_ov = '0; exp_od = '0;
    end else begin
      exp_rd = '0;
      if (bus.chipselect && bus.read) begin
        if (bus.address == 0) exp_rd = ctrl_m;
        else if (bus.address == 1) exp_rd = status_m();
        else if (bus.address >= 2 && bus.address < 2 + NP) begin
          if (mq[bus.address - 2].size() > 0) exp_rd = mq[bus.address - 2].pop_front();
        end
      end
      exp_ov = '0; exp_od = '0;
      if (bus.chipselect && bus.write) begin
        if (bus.address == 0) ctrl_m = bus.writedata;
        else if (bus.address == 1) ovf_m = ovf_m & ~bus.writedata[NP +: NP];
        else if (bus.address >= 2 && bus.address < 2 + NP) begin
          exp_ov[bus.address - 2] = 1'b1;
          exp_od = bus.writedata;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (in_valid[p]) begin
          if (mq[p].size() < DEPTH) mq[p].push_back(in_data[p*DW +: DW]);
          else ovf_m[p] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("readdata", bus.readdata, exp_rd);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_data", out_data, exp_od);
      chk("experimenting", 32'(experimenting), 32'(ctrl_m[1:0] == 2'd2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.chipselect = 0; bus.write = 0; bus.read = 0;
    bus.address = '0; bus.writedata = '0;
    in_valid = '0; in_data = '0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    bus.chipselect = 1; bus.write = 1; bus.address = a; bus.writedata = d;
    step();
    idle();
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    bus.chipselect = 1; bus.read = 1; bus.address = a;
    step();
    d = bus.readdata;
    idle();
  endtask

  task automatic push(input int p, input logic [31:0] d);
    in_valid[p] = 1'b1;
    in_data[p*DW +: DW] = d;
    step();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    idle();
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1;
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_experimenting", 32'(experimenting), 32'h0);

    wr_reg(4'd0, 32'h2);
    chk("ctrl2_experimenting", 32'(experimenting), 32'h1);
    rd_reg(4'd0, r);
    chk("ctrl_read", r, 32'h2);
    wr_reg(4'd0, 32'h1);
    chk("ctrl1_experimenting", 32'(experimenting), 32'h0);

    wr_reg(4'd4, 32'hDEAD_BEEF);
    chk("tx_valid", 32'(out_valid), 32'h4);
    chk("tx_data", out_data, 32'hDEAD_BEEF);
    step();
    chk("tx_valid_clr", 32'(out_valid), 32'h0);
    chk("tx_data_clr", out_data, 32'h0);

    wr_reg(4'd3, 32'h1);
    wr_reg(4'd5, 32'h2);
    chk("tx_b2b", 32'(out_valid), 32'h8);

    push(1, 32'h11);
    push(1, 32'h22);
    rd_reg(4'd1, r);
    chk("status_p1_ne", r, 32'h2);
    rd_reg(4'd3, r); chk("p1_pop0", r, 32'h11);
    rd_reg(4'd3, r); chk("p1_pop1", r, 32'h22);
    rd_reg(4'd3, r); chk("p1_empty", r, 32'h0);
    rd_reg(4'd1, r); chk("status_p1_clr", r, 32'h0);

    for (int k = 1; k <= 9; k++) push(0, 32'(k));
    rd_reg(4'd1, r); chk("status_ovf0", r, 32'h111);
    wr_reg(4'd1, 32'h10);
    rd_reg(4'd1, r); chk("status_ovf0_clr", r, 32'h101);
    for (int k = 1; k <= 8; k++) begin
      rd_reg(4'd2, r); chk("p0_drain", r, 32'(k));
    end
    rd_reg(4'd2, r); chk("p0_no_word9", r, 32'h0);

    for (int k = 0; k < 8; k++) push(3, 32'h30 + 32'(k));
    in_valid[3] = 1'b1; in_data[3*DW +: DW] = 32'h38;
    rd_reg(4'd5, r);
    chk("p3_full_pushpop", r, 32'h30);
    rd_reg(4'd1, r); chk("status_p3_full", r, 32'h808);
    for (int k = 1; k <= 8; k++) begin
      rd_reg(4'd5, r); chk("p3_order", r, 32'h30 + 32'(k));
    end

    in_valid[2] = 1'b1; in_data[2*DW +: DW] = 32'h55;
    rd_reg(4'd4, r);
    chk("p2_empty_pushpop", r, 32'h0);
    rd_reg(4'd4, r); chk("p2_landed", r, 32'h55);

    for (int k = 0; k < 4; k++) begin
      in_valid = '1;
      for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = 32'(16*p + k + 1);
      step();
      idle();
    end
    rd_reg(4'd1, r); chk("status_half", r, 32'hF);
    bus.chipselect = 1; bus.write = 1; bus.address = 4'd2; bus.writedata = 32'hAA;
    reset = 1'b1;
    step();
    idle();
    chk("rst_pulse_killed", 32'(out_valid), 32'h0);
    reset = 1'b0;
    rd_reg(4'd1, r); chk("rst_status", r, 32'h0);
    for (int p = 0; p < NP; p++) begin
      rd_reg(4'(2 + p), r); chk("rst_port_empty", r, 32'h0);
    end
    step();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
